// File: rtl/hwpf_stride_detector.sv
// hwpf_stride_detector
//   Self-training stride detector for the HPDcache hardware prefetcher.
//   The detector watches demand addresses and keeps one table entry per
//   tracking region. Each entry holds a tag, the last index, the current
//   stride, a confidence counter and an LRU age. When the same non-zero
//   stride repeats until the confidence threshold is reached, the detector
//   issues up to DEGREE line-aligned prefetch requests. The burst stops
//   early when a target would leave the region.
//
// Ports
//   clk_i, rst_i          clock and synchronous active-high reset
//   enable_i              training enable; snoops are not accepted while low
//   flush_i               invalidate the whole table and reset the LRU ages
//   snoop_valid_i/_ready_o/snoop_addr_i   demand-address snoop handshake
//   pf_req_valid_o/_ready_i/pf_req_addr_o prefetch request handshake
//   pf_issued_cnt_o       wrapping count of accepted prefetch requests
//   busy_o                issue FSM is not idle
module hwpf_stride_detector #(
  parameter int ADDR_W      = 49,
  parameter int LINE_W      = 6,
  parameter int REGION_W    = 12,
  parameter int TABLE_SIZE  = 32,
  parameter int CONF_W      = 2,
  parameter int CONF_THRESH = 3,
  parameter int DEGREE      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              snoop_valid_i,
  output logic              snoop_ready_o,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              pf_req_valid_o,
  input  logic              pf_req_ready_i,
  output logic [ADDR_W-1:0] pf_req_addr_o,
  output logic [31:0]       pf_issued_cnt_o,
  output logic              busy_o
);

  localparam int TAG_W  = ADDR_W - REGION_W;
  localparam int AGE_W  = $clog2(TABLE_SIZE);
  localparam int BEAT_W = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam logic [CONF_W-1:0]          CONF_MAX   = '1;
  localparam logic [CONF_W-1:0]          CONF_TRIG  = CONF_W'(CONF_THRESH);
  localparam logic [AGE_W-1:0]           AGE_OLDEST = AGE_W'(TABLE_SIZE - 1);
  localparam logic [BEAT_W-1:0]          BEAT_LAST  = BEAT_W'(DEGREE - 1);
  localparam logic signed [REGION_W:0]   LINE_STEP  = (REGION_W+1)'(2**LINE_W);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Tracking table
  logic [TABLE_SIZE-1:0]      valid_reg;
  logic [TAG_W-1:0]           tag_reg      [TABLE_SIZE];
  logic [REGION_W-1:0]        last_idx_reg [TABLE_SIZE];
  logic signed [REGION_W:0]   stride_reg   [TABLE_SIZE];
  logic [CONF_W-1:0]          conf_reg     [TABLE_SIZE];
  logic [AGE_W-1:0]           age_reg      [TABLE_SIZE];

  // Issue FSM and burst context
  state_t                     state_reg, state_next;
  logic [BEAT_W-1:0]          beat_reg;
  logic signed [REGION_W+1:0] cur_reg;    // offset of the last issued (or base) target
  logic signed [REGION_W:0]   step_reg;
  logic [TAG_W-1:0]           burst_tag_reg;
  logic                       flush_pend_reg;
  logic [31:0]                cnt_reg;

  logic [TAG_W-1:0]           snoop_tag;
  logic [REGION_W-1:0]        snoop_idx;
  logic [TABLE_SIZE-1:0]      hit_vec, free_vec, oldest_vec;
  logic                       hit_any, free_any;
  logic [AGE_W-1:0]           hit_sel, free_sel, old_sel, sel;
  logic [AGE_W-1:0]           sel_age;
  logic signed [REGION_W:0]   delta;
  logic [REGION_W:0]          delta_mag;
  logic                       stride_match;
  logic [CONF_W-1:0]          conf_inc;
  logic                       consume, trigger;
  logic signed [REGION_W:0]   trig_step;
  logic signed [REGION_W+1:0] target;
  logic                       in_range, handshake;

  assign snoop_tag = snoop_addr_i[ADDR_W-1:REGION_W];
  assign snoop_idx = snoop_addr_i[REGION_W-1:0];

  generate
    for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_match
      assign hit_vec[gi]    = valid_reg[gi] && (tag_reg[gi] == snoop_tag);
      assign free_vec[gi]   = ~valid_reg[gi];
      assign oldest_vec[gi] = (age_reg[gi] == AGE_OLDEST);
    end
  endgenerate

  // Entry selection: the hit entry, else the lowest free entry, else the LRU one.
  always_comb begin
    hit_any  = |hit_vec;
    free_any = |free_vec;
    hit_sel  = '0;
    free_sel = '0;
    old_sel  = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_sel  = AGE_W'(i);
      if (free_vec[i])   free_sel = AGE_W'(i);
      if (oldest_vec[i]) old_sel  = AGE_W'(i);
    end
    if (hit_any)       sel = hit_sel;
    else if (free_any) sel = free_sel;
    else               sel = old_sel;
  end

  assign sel_age      = age_reg[sel];
  assign delta        = $signed({1'b0, snoop_idx}) - $signed({1'b0, last_idx_reg[sel]});
  assign stride_match = (delta == stride_reg[sel]);
  assign conf_inc     = (conf_reg[sel] == CONF_MAX) ? CONF_MAX : conf_reg[sel] + CONF_W'(1);
  assign consume      = snoop_valid_i & snoop_ready_o;
  assign trigger      = consume & hit_any & stride_match & (delta != '0) & (conf_inc >= CONF_TRIG);

  // Strides shorter than a line would re-fetch the same line, so round them
  // up to one line in the stride's direction.
  assign delta_mag = delta[REGION_W] ? -delta : delta;
  assign trig_step = (delta_mag >= (REGION_W+1)'(2**LINE_W)) ? delta :
                     (delta[REGION_W] ? -LINE_STEP : LINE_STEP);

  // Table update
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_reg <= '0;
      for (int i = 0; i < TABLE_SIZE; i++) age_reg[i] <= AGE_W'(i);
    end else if (consume) begin
      // LRU touch: everything younger than the selected entry ages by one.
      for (int i = 0; i < TABLE_SIZE; i++) begin
        if (age_reg[i] < sel_age) age_reg[i] <= age_reg[i] + AGE_W'(1);
      end
      age_reg[sel] <= '0;
      if (hit_any) begin
        last_idx_reg[sel] <= snoop_idx;
        if (delta != '0) begin
          if (stride_match) begin
            conf_reg[sel] <= conf_inc;
          end else begin
            stride_reg[sel] <= delta;
            conf_reg[sel]   <= '0;
          end
        end
      end else begin
        valid_reg[sel]    <= 1'b1;
        tag_reg[sel]      <= snoop_tag;
        last_idx_reg[sel] <= snoop_idx;
        stride_reg[sel]   <= '0;
        conf_reg[sel]     <= '0;
      end
    end
  end

  // Next target is derived from the previous one, so it always fits in
  // REGION_W+2 signed bits and the top two bits flag leaving the region.
  assign target    = cur_reg + $signed({step_reg[REGION_W], step_reg});
  assign in_range  = (target[REGION_W+1:REGION_W] == 2'b00);
  assign handshake = pf_req_valid_o & pf_req_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    pf_req_valid_o = 1'b0;
    pf_req_addr_o  = '0;
    case (state_reg)
      IDLE: begin
        if (trigger) state_next = ISSUE;
      end
      ISSUE: begin
        if (!in_range) begin
          state_next = IDLE;
        end else begin
          pf_req_valid_o = 1'b1;
          pf_req_addr_o  = {burst_tag_reg, target[REGION_W-1:LINE_W], {LINE_W{1'b0}}};
          // A flush lets the pending beat finish but cancels the rest.
          if (pf_req_ready_i && ((beat_reg == BEAT_LAST) || flush_pend_reg || flush_i))
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_reg       <= '0;
      cur_reg        <= '0;
      step_reg       <= '0;
      burst_tag_reg  <= '0;
      flush_pend_reg <= 1'b0;
      cnt_reg        <= '0;
    end else if (trigger) begin
      beat_reg       <= '0;
      cur_reg        <= $signed({2'b00, snoop_idx});
      step_reg       <= trig_step;
      burst_tag_reg  <= snoop_tag;
      flush_pend_reg <= 1'b0;
    end else if (state_reg == ISSUE) begin
      if (flush_i) flush_pend_reg <= 1'b1;
      if (handshake) begin
        cur_reg  <= target;
        beat_reg <= beat_reg + BEAT_W'(1);
        cnt_reg  <= cnt_reg + 32'd1;
      end
    end
  end

  assign snoop_ready_o   = (state_reg == IDLE) & enable_i & ~flush_i;
  assign busy_o          = (state_reg != IDLE);
  assign pf_issued_cnt_o = cnt_reg;

endmodule
